// File: rtl/seq_tx_1011_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seq_tx_1011_pkg
//  Purpose : Shared state encodings and default pattern for the 1011 serial
//            link (transmitter and detector bench).
//  Rev     : 1.0  initial release
// ============================================================================
package seq_tx_1011_pkg;

   // Transmitter FSM states; codes 4..7 are unused and fall back to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEND   = 3'd1,
      ST_GAP    = 3'd2,
      ST_FINISH = 3'd3
   } tx_state_e;

   localparam int         DEFAULT_PAT_W   = 4;
   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage : seq_tx_1011_pkg
`default_nettype wire

// File: rtl/seq_tx_1011_if.sv
`default_nettype none
// ============================================================================
//  Module  : seq_tx_1011_if
//  Purpose : Request and serial-output bundle of the pattern transmitter.
//            master = requester / serial consumer, slave = transmitter.
//  Rev     : 1.0  initial release
// ============================================================================
interface seq_tx_1011_if #(
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
);
   logic             start;
   logic [CNT_W-1:0] repeat_n;
   logic [GAP_W-1:0] gap;
   logic             s_out;
   logic             valid;
   logic             busy;
   logic             frame_end;
   logic             done;

   modport master (
      output start, repeat_n, gap,
      input  s_out, valid, busy, frame_end, done
   );

   modport slave (
      input  start, repeat_n, gap,
      output s_out, valid, busy, frame_end, done
   );
endinterface : seq_tx_1011_if
`default_nettype wire

// File: rtl/seq_tx_1011_shreg.sv
`default_nettype none
// ============================================================================
//  Module  : seq_tx_1011_shreg
//  Purpose : PAT_W-bit parallel-load, MSB-first shift register. The LSB is
//            filled with FILL on every shift, so once a pattern has been
//            fully shifted out the MSB rests at the idle level.
//  Rev     : 1.0  initial release
// ============================================================================
module seq_tx_1011_shreg #(
   parameter int   PAT_W = 4,
   parameter logic FILL  = 1'b0
) (
   input  wire logic             clk_i,
   input  wire logic             rst_ni,
   input  wire logic             load_i,
   input  wire logic             shift_i,
   input  wire logic [PAT_W-1:0] data_i,
   output logic                  msb_o
);

   logic [PAT_W-1:0] shreg_q;

   // Load has priority over shift; reset parks every bit at the idle level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q <= {PAT_W{FILL}};
      end else if (load_i) begin
         shreg_q <= data_i;
      end else if (shift_i) begin
         shreg_q <= {shreg_q[PAT_W-2:0], FILL};
      end
   end

   assign msb_o = shreg_q[PAT_W-1];

endmodule : seq_tx_1011_shreg
`default_nettype wire

// File: rtl/seq_tx_1011.sv
`default_nettype none
// ============================================================================
//  Module  : seq_tx_1011
//  Purpose : Serial pattern transmitter. On start, sends PATTERN MSB first,
//            REPEAT times (0 means 1), with GAP idle cycles between frames.
//            All outputs come straight from flops.
//  Rev     : 1.0  initial release
// ============================================================================
module seq_tx_1011
   import seq_tx_1011_pkg::*;
#(
   parameter int               PAT_W    = DEFAULT_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN  = PAT_W'(DEFAULT_PATTERN),
   parameter int               CNT_W    = 4,
   parameter int               GAP_W    = 3,
   parameter logic             IDLE_LVL = 1'b0
) (
   input  wire logic     clk_i,
   input  wire logic     rst_ni,
   seq_tx_1011_if.slave  bus
);

   localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

   tx_state_e        state_q, state_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [CNT_W-1:0] frames_q, frames_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_len_q, gap_len_d;
   logic             valid_q, valid_d;
   logic             frame_end_q, frame_end_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_w;

   // Next-state, counter updates and next-cycle (registered) output values.
   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      frames_d  = frames_q;
      gap_d     = gap_q;
      gap_len_d = gap_len_q;
      load_w    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d   = ST_SEND;
               load_w    = 1'b1;
               bit_d     = '0;
               frames_d  = (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
               gap_len_d = bus.gap;
            end
         end
         ST_SEND: begin
            if (bit_q == LAST_BIT) begin
               bit_d = '0;
               if (frames_q > CNT_W'(1)) begin
                  frames_d = frames_q - CNT_W'(1);
                  if (gap_len_q != '0) begin
                     state_d = ST_GAP;
                     gap_d   = gap_len_q;
                  end else begin
                     // Back-to-back frame: reload so no bubble appears.
                     load_w  = 1'b1;
                  end
               end else begin
                  state_d  = ST_FINISH;
                  frames_d = '0;
               end
            end else begin
               bit_d = bit_q + BIT_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_q <= GAP_W'(1)) begin
               state_d = ST_SEND;
               load_w  = 1'b1;
               bit_d   = '0;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      valid_d     = (state_d == ST_SEND);
      frame_end_d = (state_d == ST_SEND) && (bit_d == LAST_BIT);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_FINISH);
   end

   // State, counters and output flags; reset aborts any transfer at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         bit_q       <= '0;
         frames_q    <= '0;
         gap_q       <= '0;
         gap_len_q   <= '0;
         valid_q     <= 1'b0;
         frame_end_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         frames_q    <= frames_d;
         gap_q       <= gap_d;
         gap_len_q   <= gap_len_d;
         valid_q     <= valid_d;
         frame_end_q <= frame_end_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // The shift register is the serial output flop: it shifts every cycle it
   // is not loaded, so after the LSB it idles at IDLE_LVL by itself.
   seq_tx_1011_shreg #(
      .PAT_W (PAT_W),
      .FILL  (IDLE_LVL)
   ) u_shreg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load_w),
      .shift_i (!load_w),
      .data_i  (PATTERN),
      .msb_o   (bus.s_out)
   );

   assign bus.valid     = valid_q;
   assign bus.frame_end = frame_end_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule : seq_tx_1011
`default_nettype wire

// File: tb/tb_seq_tx_1011.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seq_tx_1011
//  Purpose : Directed self-checking bench for seq_tx_1011 (pattern 1011).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_seq_tx_1011;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   seq_tx_1011_if #(.CNT_W(4), .GAP_W(3)) bus ();

   seq_tx_1011 #(
      .PAT_W    (4),
      .PATTERN  (4'b1011),
      .CNT_W    (4),
      .GAP_W    (3),
      .IDLE_LVL (1'b0)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic tx_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // {busy, valid, s_out, frame_end, done}
   function automatic logic [4:0] outs();
      return {bus.busy, bus.valid, bus.s_out, bus.frame_end, bus.done};
   endfunction

   // Issue one request and check every cycle until one cycle past the end.
   // poke=1 re-pulses start and alters repeat/gap mid-transfer.
   task automatic run_tx(input string name, input logic [3:0] rep, input logic [2:0] gp,
                         input bit poke, output logic [63:0] bits, output int nvalid,
                         output int nfe, output int ndone, output int done_cyc);
      logic [3:0] pat = 4'b1011;
      int reff  = (rep == 4'd0) ? 1 : int'(rep);
      int g     = int'(gp);
      int total = reff * 4 + (reff - 1) * g + 1;
      int per   = 4 + g;
      logic [4:0] exp;
      bits = '0; nvalid = 0; nfe = 0; ndone = 0; done_cyc = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.repeat_n = rep; bus.gap = gp;
      @(posedge clk);
      for (int c = 1; c <= total + 1; c++) begin
         @(negedge clk);
         if (c > total) begin
            exp = 5'b00000;
         end else if (c == total) begin
            exp = 5'b10001;
         end else if (((c - 1) % per) < 4) begin
            exp = {1'b1, 1'b1, pat[3 - ((c - 1) % per)], (((c - 1) % per) == 3), 1'b0};
         end else begin
            exp = 5'b10000;
         end
         tx_check($sformatf("%s_cyc%0d", name, c), 64'(outs()), 64'(exp));
         if (bus.valid) begin
            bits = {bits[62:0], bus.s_out};
            nvalid++;
         end
         if (bus.frame_end) nfe++;
         if (bus.done) begin
            ndone++;
            done_cyc = c;
         end
         if (poke && c == 2) begin
            bus.start = 1'b1; bus.repeat_n = 4'd9; bus.gap = 3'd5;
         end else begin
            bus.start = 1'b0;
         end
      end
   endtask

   initial begin
      logic [63:0] bits;
      int nv, nfe, nd, dc;

      rst_n = 1'b0;
      bus.start = 1'b0; bus.repeat_n = '0; bus.gap = '0;
      #12;
      tx_check("reset_state", 64'(outs()), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      tx_check("idle_after_reset", 64'(outs()), 64'h0);

      // Asynchronous reset in the middle of a frame.
      @(negedge clk);
      bus.start = 1'b1; bus.repeat_n = 4'd3; bus.gap = 3'd1;
      @(negedge clk);
      bus.start = 1'b0;
      tx_check("abort_first_bit", 64'(outs()), 64'(5'b11100));
      #2 rst_n = 1'b0;
      #1 tx_check("async_reset", 64'(outs()), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      tx_check("post_abort_idle", 64'(outs()), 64'h0);

      // Single frame; also proves the post-abort frame starts from the MSB.
      run_tx("r1g0", 4'd1, 3'd0, 1'b0, bits, nv, nfe, nd, dc);
      tx_check("r1g0_bits", bits & 64'hF, 64'b1011);
      tx_check("r1g0_done_cyc", 64'(dc), 64'd5);

      // Two back-to-back frames.
      run_tx("r2g0", 4'd2, 3'd0, 1'b0, bits, nv, nfe, nd, dc);
      tx_check("r2g0_bits", bits & 64'hFF, 64'b10111011);
      tx_check("r2g0_fe", 64'(nfe), 64'd2);

      // Three frames with two idle cycles in between.
      run_tx("r3g2", 4'd3, 3'd2, 1'b0, bits, nv, nfe, nd, dc);
      tx_check("r3g2_bits", bits & 64'hFFF, 64'b101110111011);
      tx_check("r3g2_fe", 64'(nfe), 64'd3);
      tx_check("r3g2_done_cyc", 64'(dc), 64'd17);

      // Start re-pulsed with new repeat/gap during SEND: ignored.
      run_tx("poke", 4'd2, 3'd0, 1'b1, bits, nv, nfe, nd, dc);
      tx_check("poke_valid", 64'(nv), 64'd8);
      tx_check("poke_done", 64'(nd), 64'd1);

      // Repeat of zero behaves as one frame.
      run_tx("r0", 4'd0, 3'd0, 1'b0, bits, nv, nfe, nd, dc);
      tx_check("r0_valid", 64'(nv), 64'd4);
      tx_check("r0_done", 64'(nd), 64'd1);

      // Maximum repeat count.
      run_tx("r15", 4'd15, 3'd0, 1'b0, bits, nv, nfe, nd, dc);
      tx_check("r15_valid", 64'(nv), 64'd60);
      tx_check("r15_fe", 64'(nfe), 64'd15);
      tx_check("r15_done", 64'(nd), 64'd1);
      tx_check("r15_done_cyc", 64'(dc), 64'd61);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_seq_tx_1011
`default_nettype wire
